// File: rtl/pulpino_spi_slave_pkg.sv
// Shared types and constants for the SPI slave responder.
package pulpino_spi_slave_pkg;

    localparam int unsigned MAX_FIELD_LEN = 32;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA,
        DONE
    } spi_state_e;

    typedef enum logic [1:0] {
        ST_OK      = 2'b00,
        ST_SHORT   = 2'b01,
        ST_OVERRUN = 2'b10
    } spi_status_e;

    // Lengths beyond the field width saturate at the field width.
    function automatic logic [5:0] clamp_len(input logic [15:0] len);
        if (len > 16'(MAX_FIELD_LEN)) begin
            return 6'(MAX_FIELD_LEN);
        end
        return len[5:0];
    endfunction

    // Next nonzero-length phase after cur, in CMD -> ADDR -> DATA -> DONE order.
    function automatic spi_state_e phase_after(input spi_state_e cur,
                                               input logic [5:0] c_len,
                                               input logic [5:0] a_len,
                                               input logic [5:0] d_len);
        spi_state_e nxt;
        nxt = DONE;
        if (cur == IDLE && c_len != 6'd0) begin
            nxt = CMD;
        end else if ((cur == IDLE || cur == CMD) && a_len != 6'd0) begin
            nxt = ADDR;
        end else if (cur != DATA && cur != DONE && d_len != 6'd0) begin
            nxt = DATA;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/spi_slave_sync.sv
// Multi-flop synchronizer with rise/fall detection on the synchronized value.
module spi_slave_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Shift the async input through the chain and keep the last synchronized value.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign q    = sync_q[SYNC_STAGES-1];
    assign rise = q & ~prev_q;
    assign fall = ~q & prev_q;

endmodule

// File: rtl/spi_slave_responder.sv
// SPI mode-0 slave: captures cmd/addr/data fields and returns a MISO payload.
module spi_slave_responder
    import pulpino_spi_slave_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        spi_sclk,
    input  logic        spi_csn,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_miso_oe,
    input  logic [5:0]  cmd_len,
    input  logic [5:0]  addr_len,
    input  logic [15:0] data_len,
    input  logic [31:0] tx_data,
    output logic [31:0] rx_cmd,
    output logic [31:0] rx_addr,
    output logic [31:0] rx_data,
    output logic [1:0]  rx_status,
    output logic        rx_valid
);

    localparam int unsigned FW          = MAX_FIELD_LEN;
    localparam logic [2:0]  WARM_CYCLES = 3'(SYNC_STAGES + 1);

    logic sclk_s, sclk_rise, sclk_fall;
    logic csn_s, csn_rise, csn_fall;
    logic mosi_s, mosi_rise, mosi_fall;

    spi_slave_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b0)
    ) u_sync_sclk (
        .clk  (clk),
        .rstn (rstn),
        .d    (spi_sclk),
        .q    (sclk_s),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    spi_slave_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b1)
    ) u_sync_csn (
        .clk  (clk),
        .rstn (rstn),
        .d    (spi_csn),
        .q    (csn_s),
        .rise (csn_rise),
        .fall (csn_fall)
    );

    spi_slave_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b0)
    ) u_sync_mosi (
        .clk  (clk),
        .rstn (rstn),
        .d    (spi_mosi),
        .q    (mosi_s),
        .rise (mosi_rise),
        .fall (mosi_fall)
    );

    logic unused_edges;
    assign unused_edges = ^{sclk_s, mosi_rise, mosi_fall};

    spi_state_e    state_q;
    spi_state_e    next_phase;
    logic [5:0]    cmd_len_q, addr_len_q, data_len_q, bit_cnt_q;
    logic [5:0]    len_c, len_a, len_d, phase_len;
    logic [FW-1:0] cmd_sh_q, addr_sh_q, data_sh_q, tx_sh_q;
    logic [FW-1:0] tx_align;
    logic          overrun_q, skip_fall_q, miso_q, oe_q;
    logic          armed_q;
    logic [2:0]    warm_q;
    logic          start, last_bit;

    // Phase lengths come straight from the inputs when starting, else from the latched copy.
    always_comb begin
        start = (state_q == IDLE) && csn_fall && armed_q;
        if (state_q == IDLE) begin
            len_c = clamp_len({10'd0, cmd_len});
            len_a = clamp_len({10'd0, addr_len});
            len_d = clamp_len(data_len);
        end else begin
            len_c = cmd_len_q;
            len_a = addr_len_q;
            len_d = data_len_q;
        end
        next_phase = phase_after(state_q, len_c, len_a, len_d);
        tx_align   = tx_data << (6'(FW) - len_d);
        case (state_q)
            CMD:     phase_len = cmd_len_q;
            ADDR:    phase_len = addr_len_q;
            default: phase_len = data_len_q;
        endcase
        last_bit = (bit_cnt_q + 6'd1) == phase_len;
    end

    // Transaction FSM with field shifters, MISO shifter and overrun tracking.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            cmd_len_q   <= '0;
            addr_len_q  <= '0;
            data_len_q  <= '0;
            bit_cnt_q   <= '0;
            cmd_sh_q    <= '0;
            addr_sh_q   <= '0;
            data_sh_q   <= '0;
            tx_sh_q     <= '0;
            overrun_q   <= 1'b0;
            skip_fall_q <= 1'b0;
            miso_q      <= 1'b0;
            oe_q        <= 1'b0;
            armed_q     <= 1'b0;
            warm_q      <= '0;
        end else begin
            // Arm only once csn is seen high after the synchronizers have flushed,
            // so csn held low through reset release cannot start a transfer.
            if (warm_q != WARM_CYCLES) begin
                warm_q <= warm_q + 3'd1;
            end else if (csn_s) begin
                armed_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (start) begin
                        cmd_len_q  <= len_c;
                        addr_len_q <= len_a;
                        data_len_q <= len_d;
                        bit_cnt_q  <= '0;
                        cmd_sh_q   <= '0;
                        addr_sh_q  <= '0;
                        data_sh_q  <= '0;
                        tx_sh_q    <= '0;
                        overrun_q  <= 1'b0;
                        state_q    <= next_phase;
                        if (next_phase == DATA) begin
                            tx_sh_q     <= tx_align;
                            miso_q      <= tx_align[FW-1];
                            oe_q        <= 1'b1;
                            skip_fall_q <= 1'b0;
                        end
                    end
                end
                CMD, ADDR, DATA: begin
                    if (csn_rise) begin
                        state_q <= IDLE;
                        miso_q  <= 1'b0;
                        oe_q    <= 1'b0;
                    end else if (sclk_rise) begin
                        case (state_q)
                            CMD:     cmd_sh_q  <= {cmd_sh_q[FW-2:0], mosi_s};
                            ADDR:    addr_sh_q <= {addr_sh_q[FW-2:0], mosi_s};
                            default: data_sh_q <= {data_sh_q[FW-2:0], mosi_s};
                        endcase
                        if (last_bit) begin
                            bit_cnt_q <= '0;
                            state_q   <= next_phase;
                            if (next_phase == DATA) begin
                                tx_sh_q     <= tx_align;
                                miso_q      <= tx_align[FW-1];
                                oe_q        <= 1'b1;
                                // The falling edge closing this bit must not consume the MSB.
                                skip_fall_q <= 1'b1;
                            end else if (state_q == DATA) begin
                                miso_q <= 1'b0;
                                oe_q   <= 1'b0;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 6'd1;
                        end
                    end else if (sclk_fall && state_q == DATA) begin
                        if (skip_fall_q) begin
                            skip_fall_q <= 1'b0;
                        end else begin
                            tx_sh_q <= tx_sh_q << 1;
                            miso_q  <= tx_sh_q[FW-2];
                        end
                    end
                end
                DONE: begin
                    if (csn_rise) begin
                        state_q <= IDLE;
                    end else if (sclk_rise) begin
                        overrun_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Publish fields and status one cycle after csn rises on an active transfer.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_valid  <= 1'b0;
            rx_cmd    <= '0;
            rx_addr   <= '0;
            rx_data   <= '0;
            rx_status <= ST_OK;
        end else begin
            rx_valid <= 1'b0;
            if (csn_rise && state_q != IDLE) begin
                rx_valid <= 1'b1;
                rx_cmd   <= cmd_sh_q;
                rx_addr  <= addr_sh_q;
                rx_data  <= data_sh_q;
                if (state_q != DONE) begin
                    rx_status <= ST_SHORT;
                end else if (overrun_q) begin
                    rx_status <= ST_OVERRUN;
                end else begin
                    rx_status <= ST_OK;
                end
            end
        end
    end

    assign spi_miso    = miso_q;
    assign spi_miso_oe = oe_q;

endmodule

// File: tb/tb_spi_slave_responder.sv
// Directed bench for spi_slave_responder acting as an SPI mode-0 master.
module tb_spi_slave_responder;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        spi_sclk = 1'b0;
    logic        spi_csn = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        spi_miso;
    logic        spi_miso_oe;
    logic [5:0]  cmd_len = '0;
    logic [5:0]  addr_len = '0;
    logic [15:0] data_len = '0;
    logic [31:0] tx_data = '0;
    logic [31:0] rx_cmd, rx_addr, rx_data;
    logic [1:0]  rx_status;
    logic        rx_valid;

    int n_vec = 0;
    int n_err = 0;
    int valid_cnt = 0;
    logic [31:0] q_cmd[$];
    logic [31:0] q_addr[$];
    logic [31:0] q_data[$];

    spi_slave_responder #(
        .SYNC_STAGES (2)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .spi_sclk    (spi_sclk),
        .spi_csn     (spi_csn),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .cmd_len     (cmd_len),
        .addr_len    (addr_len),
        .data_len    (data_len),
        .tx_data     (tx_data),
        .rx_cmd      (rx_cmd),
        .rx_addr     (rx_addr),
        .rx_data     (rx_data),
        .rx_status   (rx_status),
        .rx_valid    (rx_valid)
    );

    always #5 clk = ~clk;

    // Count valid cycles and log the fields carried by each pulse.
    always @(negedge clk) begin
        if (rx_valid) begin
            valid_cnt++;
            q_cmd.push_back(rx_cmd);
            q_addr.push_back(rx_addr);
            q_data.push_back(rx_data);
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Master transfer: sclk half period is 4 clk; miso/oe sampled at each sclk rise.
    task automatic xfer(input int nbits, input logic [63:0] mo, input int gap, input bit raise,
                        output logic [63:0] mi, output logic [63:0] oe_bits);
        mi = '0;
        oe_bits = '0;
        spi_csn = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = nbits - 1; i >= 0; i--) begin
            spi_mosi = mo[i];
            repeat (4) @(negedge clk);
            spi_sclk = 1'b1;
            mi = {mi[62:0], spi_miso};
            oe_bits = {oe_bits[62:0], spi_miso_oe};
            repeat (4) @(negedge clk);
            spi_sclk = 1'b0;
        end
        if (raise) begin
            repeat (4) @(negedge clk);
            spi_csn = 1'b1;
            spi_mosi = 1'b0;
            repeat (gap) @(negedge clk);
        end
    endtask

    initial begin
        logic [63:0] mi, mi2, oe;
        int base, qb;

        repeat (3) @(negedge clk);
        chk("reset_valid", rx_valid, 0);
        chk("reset_status", rx_status, 0);
        chk("reset_data", rx_data, 0);
        chk("reset_oe", spi_miso_oe, 0);
        chk("reset_miso", spi_miso, 0);
        rstn = 1'b1;
        repeat (6) @(negedge clk);

        // Full 8/24/32 transfer
        cmd_len = 6'd8; addr_len = 6'd24; data_len = 16'd32; tx_data = 32'hCAFE_F00D;
        base = valid_cnt;
        xfer(64, {8'hEB, 24'h123456, 32'hDEAD_BEEF}, 10, 1'b1, mi, oe);
        chk("full_valid_cnt", valid_cnt - base, 1);
        chk("full_cmd", rx_cmd, 32'hEB);
        chk("full_addr", rx_addr, 32'h0012_3456);
        chk("full_data", rx_data, 32'hDEAD_BEEF);
        chk("full_status", rx_status, 2'b00);
        chk("full_miso_data", mi[31:0], 32'hCAFE_F00D);
        chk("full_miso_pre", mi[63:32], 0);
        chk("full_oe_window", oe, 64'h0000_0000_FFFF_FFFF);
        chk("full_oe_after", spi_miso_oe, 0);

        // Data-only transfer
        cmd_len = 6'd0; addr_len = 6'd0; data_len = 16'd8; tx_data = 32'h3C;
        base = valid_cnt;
        xfer(8, 64'hA5, 10, 1'b1, mi, oe);
        chk("dataonly_valid_cnt", valid_cnt - base, 1);
        chk("dataonly_data", rx_data, 32'hA5);
        chk("dataonly_cmd", rx_cmd, 0);
        chk("dataonly_addr", rx_addr, 0);
        chk("dataonly_miso", mi[7:0], 8'h3C);
        chk("dataonly_status", rx_status, 2'b00);

        // Short transfer: csn rises after 12 bits
        cmd_len = 6'd8; addr_len = 6'd8; data_len = 16'd16; tx_data = 32'h0;
        base = valid_cnt;
        xfer(12, 64'h9FB, 10, 1'b1, mi, oe);
        chk("short_valid_cnt", valid_cnt - base, 1);
        chk("short_cmd", rx_cmd, 32'h9F);
        chk("short_addr", rx_addr, 32'h0B);
        chk("short_data", rx_data, 0);
        chk("short_status", rx_status, 2'b01);

        // Reset mid-ADDR, then csn held low through reset release
        cmd_len = 6'd8; addr_len = 6'd8; data_len = 16'd8; tx_data = 32'h96;
        base = valid_cnt;
        xfer(11, {53'd0, 8'hA1, 3'b010}, 0, 1'b0, mi, oe);
        rstn = 1'b0;
        #1;
        chk("rst_valid", rx_valid, 0);
        chk("rst_cmd", rx_cmd, 0);
        chk("rst_addr", rx_addr, 0);
        chk("rst_status", rx_status, 0);
        chk("rst_miso", spi_miso, 0);
        chk("rst_oe", spi_miso_oe, 0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (6) @(negedge clk);
        xfer(4, 64'hF, 10, 1'b1, mi, oe);
        chk("rst_no_valid", valid_cnt - base, 0);
        base = valid_cnt;
        xfer(24, 64'hA1_5C3E, 10, 1'b1, mi, oe);
        chk("post_rst_valid_cnt", valid_cnt - base, 1);
        chk("post_rst_cmd", rx_cmd, 32'hA1);
        chk("post_rst_addr", rx_addr, 32'h5C);
        chk("post_rst_data", rx_data, 32'h3E);
        chk("post_rst_miso", mi[7:0], 8'h96);
        chk("post_rst_status", rx_status, 2'b00);

        // data_len clamps to 32; two extra clocks give overrun
        cmd_len = 6'd0; addr_len = 6'd0; data_len = 16'd100; tx_data = 32'h8000_0001;
        base = valid_cnt;
        xfer(34, 64'h48D1_59E3, 10, 1'b1, mi, oe);
        chk("ovr_valid_cnt", valid_cnt - base, 1);
        chk("ovr_data", rx_data, 32'h1234_5678);
        chk("ovr_status", rx_status, 2'b10);
        chk("ovr_miso", mi[33:0], 34'h2_0000_0004);

        // All lengths zero: straight to DONE
        cmd_len = 6'd0; addr_len = 6'd0; data_len = 16'd0;
        base = valid_cnt;
        xfer(0, 64'h0, 10, 1'b1, mi, oe);
        chk("zero_valid_cnt", valid_cnt - base, 1);
        chk("zero_status", rx_status, 2'b00);
        chk("zero_data", rx_data, 0);

        // Back-to-back transfers, csn high for 4 clk between them
        cmd_len = 6'd8; addr_len = 6'd8; data_len = 16'd8; tx_data = 32'h77;
        base = valid_cnt;
        qb = q_cmd.size();
        xfer(24, 64'h11_2233, 4, 1'b1, mi, oe);
        tx_data = 32'h88;
        xfer(24, 64'h44_5566, 10, 1'b1, mi2, oe);
        chk("b2b_valid_cnt", valid_cnt - base, 2);
        if (q_cmd.size() >= qb + 2) begin
            chk("b2b_cmd0", q_cmd[qb], 32'h11);
            chk("b2b_addr0", q_addr[qb], 32'h22);
            chk("b2b_data0", q_data[qb], 32'h33);
            chk("b2b_cmd1", q_cmd[qb+1], 32'h44);
            chk("b2b_addr1", q_addr[qb+1], 32'h55);
            chk("b2b_data1", q_data[qb+1], 32'h66);
        end
        chk("b2b_miso0", mi[7:0], 8'h77);
        chk("b2b_miso1", mi2[7:0], 8'h88);
        chk("b2b_hold_data", rx_data, 32'h66);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spi_slave_responder.md
SPI_SLAVE_RESPONDER -- requirements
Module: spi_slave_responder

Interface
REQ-001 Parameter SYNC_STAGES, default 2: flop depth of the sclk/csn/mosi synchronizers, legal range 2..3.
REQ-002 clk  in  1  system clock; must run at least 4x the sclk frequency.
REQ-003 rstn  in  1  reset: asynchronous, active-low.
REQ-004 spi_sclk  in  1  SPI clock from master; mode 0 (CPOL=0, CPHA=0).
REQ-005 spi_csn  in  1  chip select, active-low.
REQ-006 spi_mosi  in  1  serial data from master, MSB first.
REQ-007 spi_miso  out  1  serial data to master, MSB first.
REQ-008 spi_miso_oe  out  1  high while the DATA phase is active and csn is low.
REQ-009 cmd_len  in  6  command bit count, 0..32.
REQ-010 addr_len  in  6  address bit count, 0..32.
REQ-011 data_len  in  16  data bit count; values above 32 clamp to 32.
REQ-012 tx_data  in  32  MISO payload, right-aligned; sampled on DATA-phase entry.
REQ-013 rx_cmd / rx_addr / rx_data  out  32 each  captured fields, right-aligned, unused MSBs zero.
REQ-014 rx_status  out  2  00 complete, 01 short (csn rose early), 10 overrun (extra sclk edges).
REQ-015 rx_valid  out  1  one-clk pulse: captured fields and status are valid.

Function
REQ-016 sclk, csn and mosi pass through SYNC_STAGES flops; rising/falling sclk and csn edges are detected on the synchronized signals.
REQ-017 FSM states: IDLE, CMD, ADDR, DATA, DONE.
REQ-018 IDLE -> CMD on a synchronized csn falling edge; cmd_len, addr_len and clamped data_len are latched at this point, and all field registers and bit counters clear.
REQ-019 Phases with zero length are skipped: CMD -> ADDR -> DATA -> DONE in that order, each entered only if its length is nonzero.
REQ-020 Each phase shifts one mosi bit into its field register per sclk rising edge (left shift, LSB in).
REQ-021 The phase advances on the rising edge that captures its last bit.
REQ-022 On DATA entry, tx_data is loaded into the tx shift register left-aligned to the clamped data_len, and spi_miso immediately presents bit data_len-1.
REQ-023 spi_miso shifts to the next bit on each sclk falling edge inside DATA; it is 0 outside DATA.
REQ-024 DONE: further sclk rising edges while csn is low set the overrun flag and are otherwise ignored.
REQ-025 Synchronized csn rising edge in CMD/ADDR/DATA: go to IDLE with status 01; fields hold the partial bits shifted so far.
REQ-026 Synchronized csn rising edge in DONE: go to IDLE with status 10 if overrun, else 00.
REQ-027 rx_valid pulses exactly one clk, the cycle after the csn rising edge is detected; rx_* fields and rx_status are updated on that same cycle and held until the next pulse.
REQ-028 A csn rising edge in IDLE produces no rx_valid.
REQ-029 If all three lengths are 0, csn falling goes straight to DONE.
REQ-030 A csn falling and rising edge in the same synchronized sample cannot occur; csn low for under 2 clk cycles is undefined.

Reset
REQ-031 rstn low asynchronously forces: FSM IDLE, all shift registers and counters 0, spi_miso 0, spi_miso_oe 0, rx_valid 0, rx_cmd/rx_addr/rx_data 0, rx_status 00, synchronizer flops 1 for csn and 0 for sclk/mosi.
REQ-032 Reset asserted mid-transaction discards it with no rx_valid.
REQ-033 After release, the block waits for a fresh csn falling edge; csn held low through reset release does not start a transaction.

Structure
REQ-034 Package pulpino_spi_slave_pkg holds the state enum, rx_status codes (ST_OK, ST_SHORT, ST_OVERRUN) and constant MAX_FIELD_LEN = 32.
REQ-035 Sub-module spi_slave_sync (synchronizer plus edge detect, parameterized by SYNC_STAGES) is instantiated once per input: sclk, csn and mosi.
REQ-036 The environment's collector packet remains the reference model: rx_cmd/addr/data map to its cmd/addr/mosi_data, and tx_data maps to miso_data.

Verification
REQ-037 cmd_len=8, addr_len=24, data_len=32, master sends cmd 0xEB, addr 0x123456, data 0xDEADBEEF, tx_data=0xCAFEF00D -> rx_cmd=0xEB, rx_addr=0x123456, rx_data=0xDEADBEEF, master reads 0xCAFEF00D, status 00, one rx_valid.
REQ-038 cmd_len=0, addr_len=0, data_len=8, mosi 0xA5, tx_data=0x3C -> rx_data=0xA5, miso 0x3C, rx_cmd=rx_addr=0.
REQ-039 cmd_len=8, addr_len=8, data_len=16, csn rises after 12 sclk (cmd 0x9F, addr nibble 0xB) -> rx_cmd=0x9F, rx_addr=0x0B, rx_data=0, status 01.
REQ-040 data_len=100, master clocks 34 bits -> 32 bits captured, status 10.
REQ-041 rstn pulsed low mid-ADDR -> all outputs 0 immediately, no rx_valid; next full 8/8/8 transfer correct.
REQ-042 Two back-to-back transfers with csn high for 4 clk between them -> two rx_valid pulses carrying independent correct fields.
